dac_serializer: RTL

- Output stage directly downstream of the soft clipper: accepts one clipped 16-bit signed sample per audio frame over a valid/ready handshake.
- Serializes it MSB-first, left-justified, to an external stereo DAC. The mono sample is duplicated into left and right slots.
- Generates the bit clock (bclk) and word select (ws) from the system clock.
- Holds one sample in a holding register and flags underruns.

---
 rtl/audio_pkg.sv | 6 +
 rtl/dac_serializer_bclk_gen.sv | 31 +++
 rtl/dac_serializer.sv | 93 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, bit-clock divider default and serializer state encoding
package audio_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CLK_DIV = 4;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/dac_serializer_bclk_gen.sv
// bclk_gen: divides clk into the DAC bit clock and flags the cycle before each bclk edge
module bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q;
  logic bclk_q, wrap;
  assign wrap = run_i & (div_q == DW'(CLK_DIV - 1));
  assign rise_o = wrap & ~bclk_q;
  assign fall_o = wrap & bclk_q;
  assign bclk_o = bclk_q;
  // Held at zero while stopped so every run begins on a fresh low half-period
  always_ff @(posedge clk) begin
    if (rst | ~run_i) begin
      div_q <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      if (wrap) bclk_q <= ~bclk_q;
    end
  end
endmodule

// File: rtl/dac_serializer.sv
// dac_serializer: buffers one mono sample and shifts it MSB-first into both slots of a left-justified stereo DAC
module dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              ws,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  localparam int BW = $clog2(2 * DATA_W);
  state_e state_q;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] sample_q, sh_q, sh_d, hold_q, load_val;
  logic hold_full_q, ws_q, sdata_q, frame_start_q, underrun_q;
  logic [CNT_W-1:0] cnt_q;
  logic rise, fall, last, load_now, xfer;
  bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk   (clk),
    .rst   (rst),
    .run_i (state_q == RUN),
    .bclk_o(bclk),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign last = bit_q == BW'(2 * DATA_W - 1);
  assign load_now = en & ((state_q == IDLE) | (fall & last));
  assign in_ready = ~hold_full_q | load_now;
  assign xfer = in_valid & in_ready;
  assign load_val = hold_full_q ? hold_q : '0;
  assign bit_d = last ? '0 : bit_q + 1'b1;
  // The right slot replays the sample from its MSB
  assign sh_d = (bit_d == BW'(DATA_W)) ? sample_q : {sh_q[DATA_W-2:0], 1'b0};
  assign ws = ws_q;
  assign sdata = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun = underrun_q;
  assign underrun_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      sample_q <= '0;
      sh_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      ws_q <= 1'b0;
      sdata_q <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      frame_start_q <= load_now;
      underrun_q <= load_now & ~hold_full_q;
      if (load_now & ~hold_full_q & ~&cnt_q) cnt_q <= cnt_q + 1'b1;
      if (xfer) hold_q <= in_data;
      hold_full_q <= xfer | (hold_full_q & ~load_now);
      if (load_now) begin
        state_q <= RUN;
        bit_q <= '0;
        sample_q <= load_val;
        sh_q <= load_val;
        ws_q <= 1'b0;
        sdata_q <= load_val[DATA_W-1];
      end else if (state_q == RUN && fall) begin
        if (last) begin
          state_q <= IDLE;
          bit_q <= '0;
          sh_q <= '0;
          ws_q <= 1'b0;
          sdata_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
          sh_q <= sh_d;
          ws_q <= bit_d >= BW'(DATA_W);
          sdata_q <= sh_d[DATA_W-1];
        end
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(rise && fall));
endmodule
